// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT butterfly datapath.
package ntt_pkg;

  localparam int unsigned Q  = 3329;
  localparam int unsigned DW = 12;

  typedef logic [DW-1:0] coeff_t;

  // Barrett shift; the truncated reciprocal leaves at most two correction
  // subtracts for any input below 2^BARRETT_K.
  localparam int unsigned BARRETT_K = 26;

endpackage

// File: rtl/barrett_reduction.sv
// Combinational Barrett reduction of a 32-bit value modulo MOD.
module barrett_reduction
  import ntt_pkg::*;
#(
  parameter int unsigned MOD = Q
) (
  input  logic [31:0] c,
  output logic [15:0] r
);

  localparam logic [63:0] MU    = (64'd1 << BARRETT_K) / 64'(MOD);
  localparam logic [31:0] MOD32 = 32'(MOD);

  logic [31:0] q_est;
  logic [31:0] r0;
  logic [31:0] r1;
  logic [31:0] r2;

  always_comb begin
    q_est = 32'(({32'd0, c} * MU) >> BARRETT_K);
    r0    = c - q_est * MOD32;
    r1    = (r0 >= MOD32) ? r0 - MOD32 : r0;
    r2    = (r1 >= MOD32) ? r1 - MOD32 : r1;
  end

  assign r = 16'(r2);

endmodule

// File: rtl/ntt_butterfly.sv
// Three-stage modular NTT butterfly with valid/ready handshake.
// Define NTT_BUTTERFLY_GS_EN to add the mode port selecting Gentleman-Sande.
module ntt_butterfly #(
  parameter int unsigned Q  = ntt_pkg::Q,
  parameter int unsigned DW = ntt_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
`ifdef NTT_BUTTERFLY_GS_EN
  input  logic          mode,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_x,
  output logic [DW-1:0] out_y
);

  localparam logic [DW:0] QW = Q[DW:0];

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QW) s = s - QW;
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + QW - {1'b0, b};
    return DW'(d);
  endfunction

  logic            gs_in;
  logic            advance;
  logic [DW-1:0]   s1_a_d;
  logic [DW-1:0]   mul_op;
  logic [2*DW-1:0] prod;

  logic            s1_valid;
  logic            s1_mode;
  logic [DW-1:0]   s1_a;
  logic [2*DW-1:0] s1_p;

  logic            s2_valid;
  logic            s2_mode;
  logic [DW-1:0]   s2_a;
  logic [DW-1:0]   s2_t;

  logic [15:0]     red;
  logic [DW-1:0]   t;
  logic [DW-1:0]   x_d;
  logic [DW-1:0]   y_d;

`ifdef NTT_BUTTERFLY_GS_EN
  assign gs_in = mode;
`else
  assign gs_in = 1'b0;
`endif

  // A whole stall freezes every stage, so the upstream ready is just the output slot being free.
  assign in_ready = !out_valid || out_ready;
  assign advance  = in_ready;

  // GS pre-computes a+b and a-b ahead of the shared multiplier, so both
  // modes share the single multiplier and the single reducer in the same slots.
  always_comb begin
    s1_a_d = in_a;
    mul_op = in_b;
    if (gs_in) begin
      s1_a_d = mod_add(in_a, in_b);
      mul_op = mod_sub(in_a, in_b);
    end
    prod = {{DW{1'b0}}, mul_op} * {{DW{1'b0}}, in_w};
  end

  barrett_reduction #(
    .MOD (Q)
  ) u_barrett (
    .c (32'(s1_p)),
    .r (red)
  );

  assign t = DW'(red);

  always_comb begin
    x_d = mod_add(s2_a, s2_t);
    y_d = mod_sub(s2_a, s2_t);
    if (s2_mode) begin
      x_d = s2_a;
      y_d = s2_t;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 1'b0;
      s1_a      <= '0;
      s1_p      <= '0;
      s2_valid  <= 1'b0;
      s2_mode   <= 1'b0;
      s2_a      <= '0;
      s2_t      <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_mode   <= gs_in;
      s1_a      <= s1_a_d;
      s1_p      <= prod;
      s2_valid  <= s1_valid;
      s2_mode   <= s1_mode;
      s2_a      <= s1_a;
      s2_t      <= t;
      out_valid <= s2_valid;
      out_x     <= x_d;
      out_y     <= y_d;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Directed self-checking bench for ntt_butterfly (hand-computed expectations).
module tb_ntt_butterfly;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic [11:0] in_w;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_x;
  logic [11:0] out_y;
`ifdef NTT_BUTTERFLY_GS_EN
  logic        mode;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  // a, b, w and hand-computed out_x, out_y
  int unsigned va[8] = '{50,   1, 100, 0, 3000,    7, 1234, 3328};
  int unsigned vb[8] = '{3000, 1,  10, 1,    1,  100,    2, 3328};
  int unsigned vw[8] = '{3000, 1,  10, 5,  500,  100, 3328,    1};
  int unsigned vx[8] = '{1763, 2, 200, 5,  171,   20, 1232, 3327};
  int unsigned vy[8] = '{1666, 0,   0, 3324, 2500, 3323, 1236,   0};

  ntt_butterfly dut (
    .clk       (clk),
    .rst       (rst),
`ifdef NTT_BUTTERFLY_GS_EN
    .mode      (mode),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int unsigned a, input int unsigned b, input int unsigned w);
    in_valid = v;
    in_a     = 12'(a);
    in_b     = 12'(b);
    in_w     = 12'(w);
  endtask

  task automatic run_single(input string tag, input int unsigned a, input int unsigned b,
                            input int unsigned w, input int unsigned ex, input int unsigned ey);
    drive(1'b1, a, b, w);
    tick();
    drive(1'b0, 0, 0, 0);
    chk({tag, "_v1"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_v2"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_v3"}, 32'(out_valid), 1);
    chk({tag, "_x"}, 32'(out_x), ex);
    chk({tag, "_y"}, 32'(out_y), ey);
    tick();
    chk({tag, "_v4"}, 32'(out_valid), 0);
  endtask

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 0, 0);
`ifdef NTT_BUTTERFLY_GS_EN
    mode = 1'b0;
`endif
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_x", 32'(out_x), 0);
    chk("rst_y", 32'(out_y), 0);
    chk("rst_ready", 32'(in_ready), 1);
    #19 rst = 1'b0;
    tick();

    run_single("basic", 5, 2, 17, 39, 3300);
    run_single("maxop", 3328, 3328, 3328, 0, 3327);

    // back-to-back, results on consecutive cycles in order
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drive(1'b1, va[k], vb[k], vw[k]);
      else       drive(1'b0, 0, 0, 0);
      tick();
      if (k >= 2 && k < 10) begin
        chk($sformatf("b2b_v%0d", k - 2), 32'(out_valid), 1);
        chk($sformatf("b2b_x%0d", k - 2), 32'(out_x), vx[k-2]);
        chk($sformatf("b2b_y%0d", k - 2), 32'(out_y), vy[k-2]);
      end else begin
        chk($sformatf("b2b_idle%0d", k), 32'(out_valid), 0);
      end
    end

    // downstream stall with a pending input waiting
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, va[k], vb[k], vw[k]);
      tick();
    end
    drive(1'b1, va[3], vb[3], vw[3]);
    chk("stall_ready0", 32'(in_ready), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall_ready%0d", k + 1), 32'(in_ready), 0);
      chk($sformatf("stall_v%0d", k), 32'(out_valid), 1);
      chk($sformatf("stall_x%0d", k), 32'(out_x), vx[0]);
      chk($sformatf("stall_y%0d", k), 32'(out_y), vy[0]);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(in_ready), 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      drive(1'b0, 0, 0, 0);
      chk($sformatf("drain_v%0d", k), 32'(out_valid), 1);
      chk($sformatf("drain_x%0d", k), 32'(out_x), vx[k]);
      chk($sformatf("drain_y%0d", k), 32'(out_y), vy[k]);
    end
    tick();
    chk("drain_empty", 32'(out_valid), 0);

    // reset with three transactions in flight
    for (int k = 4; k < 7; k++) begin
      drive(1'b1, va[k], vb[k], vw[k]);
      tick();
    end
    drive(1'b0, 0, 0, 0);
    chk("flight_v", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_x", 32'(out_x), 0);
    chk("midrst_y", 32'(out_y), 0);
    tick();
    chk("midrst_hold", 32'(out_valid), 0);
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("stale%0d", k), 32'(out_valid), 0);
    end
    run_single("postrst", 7, 100, 100, 20, 3323);

`ifdef NTT_BUTTERFLY_GS_EN
    mode = 1'b1;
    run_single("gs1", 10, 3, 2, 13, 14);
    run_single("gs2", 0, 1, 1, 1, 3328);
    mode = 1'b0;
    run_single("gs_ct", 5, 2, 17, 39, 3300);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
